// File: rtl/accelerator_memory_retention_engine_if.sv
// Handshake and data bundle between the DNC memory path and the retention engine.
// The slave modport is the engine side; the master modport is the host/driver side.
interface accelerator_memory_retention_engine_if #(
  parameter int DATA_SIZE = 32
);
  logic                 START;
  logic                 READY;
  logic                 ERROR;
  logic [DATA_SIZE-1:0] SIZE_R_IN;
  logic [DATA_SIZE-1:0] SIZE_N_IN;
  logic                 F_OUT_ENABLE;
  logic                 F_IN_ENABLE;
  logic [DATA_SIZE-1:0] F_IN;
  logic                 W_OUT_I_ENABLE;
  logic                 W_OUT_J_ENABLE;
  logic                 W_IN_I_ENABLE;
  logic                 W_IN_J_ENABLE;
  logic [DATA_SIZE-1:0] W_IN;
  logic                 PSI_OUT_ENABLE;
  logic [DATA_SIZE-1:0] PSI_OUT;

  modport master (
    output START, SIZE_R_IN, SIZE_N_IN, F_IN_ENABLE, F_IN,
           W_IN_I_ENABLE, W_IN_J_ENABLE, W_IN,
    input  READY, ERROR, F_OUT_ENABLE, W_OUT_I_ENABLE, W_OUT_J_ENABLE,
           PSI_OUT_ENABLE, PSI_OUT
  );

  modport slave (
    input  START, SIZE_R_IN, SIZE_N_IN, F_IN_ENABLE, F_IN,
           W_IN_I_ENABLE, W_IN_J_ENABLE, W_IN,
    output READY, ERROR, F_OUT_ENABLE, W_OUT_I_ENABLE, W_OUT_J_ENABLE,
           PSI_OUT_ENABLE, PSI_OUT
  );
endinterface

// File: rtl/accelerator_memory_retention_engine.sv
// DNC retention vector: psi[j] = prod_i (1 - f[i]*w[i][j]), fixed point, single head-major pass over W.
// Define ACCELERATOR_RETENTION_ROUNDING_EN to round (instead of truncate) both fraction shifts.
module accelerator_memory_retention_engine #(
  parameter int DATA_SIZE     = 32,
  parameter int FRACTION_BITS = 16,
  parameter int MAX_N         = 64,
  parameter int CONTROL_SIZE  = 32
) (
  input logic CLK,
  input logic RST,
  accelerator_memory_retention_engine_if.slave bus
);
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PW = 2 * DATA_SIZE;
  localparam logic [DATA_SIZE-1:0]    ONE   = DATA_SIZE'(1) << FRACTION_BITS;
  localparam logic [PW-1:0]           ONE_W = {{DATA_SIZE{1'b0}}, ONE};
  localparam logic [CONTROL_SIZE-1:0] C_ONE = CONTROL_SIZE'(1);
  localparam logic [AW-1:0]           IDX0  = '0;
`ifdef ACCELERATOR_RETENTION_ROUNDING_EN
  localparam logic [PW-1:0] RND = PW'(1) << (FRACTION_BITS - 1);
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ_F, S_WAIT_F, S_ROW, S_OUTPUT} state_t;
  state_t state;

  logic [DATA_SIZE-1:0]    r_q, n_q, f_q, psi_out_q;
  logic [CONTROL_SIZE-1:0] i_q, j_q;
  logic ones_q, ready_q, error_q, f_req_q, w_i_req_q, w_j_en_q, psi_en_q;
  logic [DATA_SIZE-1:0]    psi_mem [MAX_N];

  logic [AW-1:0]        j_idx;
  logic [PW-1:0]        fw_prod, fw_shift, pp_prod, pp_shift;
  logic [DATA_SIZE-1:0] p_clamp, term, psi_new, psi_cur;
  logic first_el, last_el, last_row, frame_ok, accept;

  assign j_idx = j_q[AW-1:0];

  always_comb begin
    psi_cur  = psi_mem[j_idx];
    fw_prod  = {{DATA_SIZE{1'b0}}, f_q} * {{DATA_SIZE{1'b0}}, bus.W_IN};
    fw_shift = (fw_prod + RND) >> FRACTION_BITS;
    p_clamp  = (fw_shift > ONE_W) ? ONE : fw_shift[DATA_SIZE-1:0];
    term     = ONE - p_clamp;
    // Row 0 seeds the buffer directly, so no separate initialisation pass is needed.
    pp_prod  = {{DATA_SIZE{1'b0}}, psi_cur} * {{DATA_SIZE{1'b0}}, term};
    pp_shift = (pp_prod + RND) >> FRACTION_BITS;
    if (i_q == '0)                   psi_new = term;
    else if (|pp_shift[PW-1:DATA_SIZE]) psi_new = '1;
    else                             psi_new = pp_shift[DATA_SIZE-1:0];
    first_el = (j_q == '0);
    last_el  = (j_q == CONTROL_SIZE'(n_q - DATA_SIZE'(1)));
    last_row = (i_q == CONTROL_SIZE'(r_q - DATA_SIZE'(1)));
    frame_ok = (bus.W_IN_I_ENABLE == first_el);
    accept   = (state == S_ROW) && bus.W_IN_J_ENABLE;
  end

  always_ff @(posedge CLK) begin
    if (RST && accept && frame_ok) psi_mem[j_idx] <= psi_new;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      r_q       <= '0;
      n_q       <= '0;
      f_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ones_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      f_req_q   <= 1'b0;
      w_i_req_q <= 1'b0;
      w_j_en_q  <= 1'b0;
      psi_en_q  <= 1'b0;
      psi_out_q <= '0;
    end else begin
      ready_q   <= 1'b0;
      f_req_q   <= 1'b0;
      w_i_req_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.START) begin
          r_q     <= bus.SIZE_R_IN;
          n_q     <= bus.SIZE_N_IN;
          error_q <= 1'b0;
          i_q     <= '0;
          j_q     <= '0;
          ones_q  <= 1'b0;
          if (bus.SIZE_N_IN == '0 || bus.SIZE_N_IN > DATA_SIZE'(MAX_N)) begin
            error_q <= 1'b1;
            ready_q <= 1'b1;
          end else if (bus.SIZE_R_IN == '0) begin
            state     <= S_OUTPUT;
            ones_q    <= 1'b1;
            psi_en_q  <= 1'b1;
            psi_out_q <= ONE;
            j_q       <= C_ONE;
          end else begin
            state   <= S_REQ_F;
            f_req_q <= 1'b1;
          end
        end
        S_REQ_F: state <= S_WAIT_F;
        S_WAIT_F: if (bus.F_IN_ENABLE) begin
          f_q       <= bus.F_IN;
          j_q       <= '0;
          w_i_req_q <= 1'b1;
          w_j_en_q  <= 1'b1;
          state     <= S_ROW;
        end
        S_ROW: if (bus.W_IN_J_ENABLE) begin
          if (!frame_ok) begin
            error_q  <= 1'b1;
            ready_q  <= 1'b1;
            w_j_en_q <= 1'b0;
            state    <= S_IDLE;
          end else if (last_el) begin
            w_j_en_q <= 1'b0;
            if (!last_row) begin
              i_q     <= i_q + C_ONE;
              f_req_q <= 1'b1;
              state   <= S_REQ_F;
            end else begin
              // psi[0] is final already unless N==1, where it is being written right now.
              psi_en_q  <= 1'b1;
              psi_out_q <= (n_q == DATA_SIZE'(1)) ? psi_new : psi_mem[IDX0];
              j_q       <= C_ONE;
              state     <= S_OUTPUT;
            end
          end else begin
            j_q <= j_q + C_ONE;
          end
        end
        S_OUTPUT: begin
          if (j_q < CONTROL_SIZE'(n_q)) begin
            psi_out_q <= ones_q ? ONE : psi_cur;
            j_q       <= j_q + C_ONE;
          end else begin
            psi_en_q  <= 1'b0;
            psi_out_q <= '0;
            ready_q   <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.READY          = ready_q;
  assign bus.ERROR          = error_q;
  assign bus.F_OUT_ENABLE   = f_req_q;
  assign bus.W_OUT_I_ENABLE = w_i_req_q;
  assign bus.W_OUT_J_ENABLE = w_j_en_q;
  assign bus.PSI_OUT_ENABLE = psi_en_q;
  assign bus.PSI_OUT        = psi_out_q;
endmodule

// File: tb/tb_accelerator_memory_retention_engine.sv
// Scoreboard bench for the retention engine: driver pushes expected psi/error, monitor pops on outputs.
module tb_accelerator_memory_retention_engine;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  accelerator_memory_retention_engine_if bus ();

  accelerator_memory_retention_engine dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_psi [$];
  bit          exp_err [$];
  logic [31:0] fv [8];
  logic [31:0] wv [8][64];
  bit          prev_en = 1'b0;

  // Reference: straight product over heads starting from ONE, in wide arithmetic.
  function automatic logic [31:0] model_psi(input int r, input int j);
    logic [63:0] acc, p, rnd;
`ifdef ACCELERATOR_RETENTION_ROUNDING_EN
    rnd = 64'h8000;
`else
    rnd = 64'h0;
`endif
    acc = 64'h10000;
    for (int i = 0; i < r; i++) begin
      p = (64'(fv[i]) * 64'(wv[i][j]) + rnd) >> 16;
      if (p > 64'h10000) p = 64'h10000;
      acc = (acc * (64'h10000 - p) + rnd) >> 16;
      if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
    end
    return acc[31:0];
  endfunction

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ((which == 0 && bus.F_OUT_ENABLE) || (which == 1 && bus.READY)) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL timeout_%0s got none req %0d", which == 0 ? "f_req" : "ready", 1);
    end
  endtask

  task automatic run_job(input int r, input int n, input int fe, input bit gaps, input bit rst_mid);
    bit ok, valid_n;
    valid_n = (n > 0 && n <= 64);
    if (!rst_mid) begin
      if (valid_n && fe < 0) for (int j = 0; j < n; j++) exp_psi.push_back(model_psi(r, j));
      exp_err.push_back(!(valid_n && fe < 0));
    end
    @(negedge CLK);
    bus.START = 1'b1; bus.SIZE_R_IN = r; bus.SIZE_N_IN = n;
    @(negedge CLK);
    bus.START = 1'b0; bus.SIZE_R_IN = $urandom; bus.SIZE_N_IN = $urandom;
    tests++;
    if (bus.ERROR !== !valid_n) begin
      fails++; $display("FAIL error_at_start got %0b exp %0b", bus.ERROR, !valid_n);
    end
    if (valid_n && r > 0) begin
      for (int i = 0; i < r; i++) begin
        wait_for(0, ok);
        if (!ok) return;
        if (gaps) begin bus.W_IN_J_ENABLE = 1'b1; bus.W_IN = $urandom; end
        @(negedge CLK);
        bus.W_IN_J_ENABLE = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
        bus.F_IN_ENABLE = 1'b1; bus.F_IN = fv[i];
        @(negedge CLK);
        bus.F_IN_ENABLE = 1'b0; bus.F_IN = $urandom;
        tests++;
        if (bus.W_OUT_I_ENABLE !== 1'b1) begin
          fails++; $display("FAIL w_row_marker got %0b exp 1", bus.W_OUT_I_ENABLE);
        end
        for (int j = 0; j < n; j++) begin
          if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
          tests++;
          if (bus.W_OUT_J_ENABLE !== 1'b1) begin
            fails++; $display("FAIL w_accept_level got %0b exp 1 (i=%0d j=%0d)", bus.W_OUT_J_ENABLE, i, j);
          end
          bus.W_IN_J_ENABLE = 1'b1; bus.W_IN = wv[i][j];
          bus.W_IN_I_ENABLE = (j == 0) || (j == fe);
          @(negedge CLK);
          bus.W_IN_J_ENABLE = 1'b0; bus.W_IN_I_ENABLE = 1'b0;
          if (j == fe) break;
          if (rst_mid && i == 1 && j == 1) begin
            RST = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
            tests++;
            if ({bus.READY, bus.ERROR, bus.F_OUT_ENABLE, bus.W_OUT_I_ENABLE, bus.W_OUT_J_ENABLE,
                 bus.PSI_OUT_ENABLE, bus.PSI_OUT} !== '0) begin
              fails++; $display("FAIL rst_mid_outputs got %b/%h exp 0/0",
                {bus.READY, bus.ERROR, bus.F_OUT_ENABLE, bus.W_OUT_I_ENABLE, bus.W_OUT_J_ENABLE,
                 bus.PSI_OUT_ENABLE}, bus.PSI_OUT);
            end
            return;
          end
        end
        if (fe >= 0) break;
      end
    end
    wait_for(1, ok);
    @(negedge CLK);
  endtask

  task automatic fill_rand(input int r, input int n);
    for (int i = 0; i < r; i++) begin
      fv[i] = $urandom_range(0, 32'h20000);
      for (int j = 0; j < n; j++) wv[i][j] = $urandom_range(0, 32'h10000);
    end
  endtask

  task automatic load_nominal();
    fv[0] = 32'h8000;  fv[1] = 32'h10000;
    wv[0][0] = 32'h10000; wv[0][1] = 32'h8000;
    wv[1][0] = 32'h8000;  wv[1][1] = 32'h0;
  endtask

  // Monitor: every PSI beat and READY pulse is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (bus.PSI_OUT_ENABLE) begin
          tests++;
          if (exp_psi.size() == 0) begin
            fails++; $display("FAIL psi_unexpected got %h exp none", bus.PSI_OUT);
          end else begin
            logic [31:0] e;
            e = exp_psi.pop_front();
            if (bus.PSI_OUT !== e) begin
              fails++; $display("FAIL psi_value got %h exp %h", bus.PSI_OUT, e);
            end
          end
        end else if (prev_en && exp_psi.size() != 0) begin
          tests++; fails++;
          $display("FAIL psi_gap got idle exp %0d more beats", exp_psi.size());
        end
        if (bus.READY) begin
          tests++;
          if (exp_err.size() == 0) begin
            fails++; $display("FAIL ready_unexpected got 1 exp 0");
          end else begin
            bit e;
            e = exp_err.pop_front();
            if (bus.ERROR !== e) begin
              fails++; $display("FAIL ready_error got %0b exp %0b", bus.ERROR, e);
            end
          end
          tests++;
          if (exp_psi.size() != 0) begin
            fails++; $display("FAIL psi_count got %0d missing exp 0", exp_psi.size());
          end
        end
      end
      prev_en = bus.PSI_OUT_ENABLE;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    bus.START = 0; bus.SIZE_R_IN = 0; bus.SIZE_N_IN = 0;
    bus.F_IN_ENABLE = 0; bus.F_IN = 0;
    bus.W_IN_I_ENABLE = 0; bus.W_IN_J_ENABLE = 0; bus.W_IN = 0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({bus.READY, bus.ERROR, bus.F_OUT_ENABLE, bus.W_OUT_I_ENABLE, bus.W_OUT_J_ENABLE,
         bus.PSI_OUT_ENABLE} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 000000",
        {bus.READY, bus.ERROR, bus.F_OUT_ENABLE, bus.W_OUT_I_ENABLE, bus.W_OUT_J_ENABLE, bus.PSI_OUT_ENABLE});
    end
    tests++;
    if (bus.PSI_OUT !== 32'h0) begin
      fails++; $display("FAIL reset_psi got %h exp 0", bus.PSI_OUT);
    end
    RST = 1'b1;

    load_nominal();
    run_job(2, 2, -1, 0, 0);              // 0x4000, 0xC000
    run_job(0, 3, -1, 0, 0);              // all ONE
    run_job(2, 0, -1, 0, 0);              // illegal N
    run_job(2, 65, -1, 0, 0);             // N above buffer depth
    fv[0] = 32'h20000; wv[0][0] = 32'h10000;
    run_job(1, 1, -1, 1, 0);              // clamp to zero
    fill_rand(1, 4);
    run_job(1, 4, 2, 0, 0);               // framing error on j=2
    repeat (3) @(negedge CLK);
    tests++;
    if (bus.ERROR !== 1'b1) begin
      fails++; $display("FAIL error_sticky got %0b exp 1", bus.ERROR);
    end
    fill_rand(2, 4);
    run_job(2, 4, -1, 0, 1);              // reset during row 1
    repeat (2) @(negedge CLK);
    load_nominal();
    run_job(2, 2, -1, 1, 0);
    fv[0] = 32'h1; wv[0][0] = 32'h8000;
    run_job(1, 1, -1, 0, 0);              // rounding-sensitive
    fill_rand(1, 64);
    run_job(1, 64, -1, 0, 0);             // full buffer
    for (int t = 0; t < 20; t++) begin
      int r, n;
      r = $urandom_range(1, 4);
      n = (t % 5 == 0) ? 64 : $urandom_range(1, 24);
      fill_rand(r, n);
      run_job(r, n, -1, t[0], 0);
    end

    repeat (4) @(negedge CLK);
    tests++;
    if (exp_psi.size() != 0 || exp_err.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got %0d/%0d left exp 0/0", exp_psi.size(), exp_err.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
